// File: rtl/frame_gate_ctrl.sv
// Frame gate between camera timing and the RGB-to-YCbCr stage: passes, drops or blocks whole frames.
// All outputs are registered and lag the inputs by 1 clk. The stream has no backpressure.
module frame_gate_ctrl #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [1:0]       i_skip,
    input  logic             i_v_sync,
    input  logic             i_h_sync,
    input  logic             i_data_en,
    input  logic [15:0]      i_rgb565,
    output logic             o_v_sync,
    output logic             o_h_sync,
    output logic             o_data_en,
    output logic [15:0]      o_rgb565,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_frame_err,
    output logic             o_busy
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, PASS, DROP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_LEN   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_LEN   = CNT_W'(V_ACT);

    state_t           state;
    logic [1:0]       skip_cnt;
    logic             vs_d;
    logic             de_d;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;

    logic             fb;
    logic             in_pass;
    logic             gated_de;
    logic             line_end;
    logic             sof_hit;
    logic             len_err;
    logic             cnt_err;
    logic [CNT_W-1:0] x_inc;
    logic [CNT_W-1:0] y_inc;
    logic [CNT_W-1:0] y_line;

    assign fb       = i_v_sync & ~vs_d;
    assign in_pass  = (state == PASS);
    assign gated_de = i_data_en & in_pass;
    assign line_end = in_pass & de_d & ~i_data_en;
    assign x_inc    = (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 1'b1;
    assign y_inc    = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 1'b1;
    // Line count including a line that ends in this very cycle, so a
    // coincident frame boundary sees the line before the count is checked.
    assign y_line   = line_end ? y_inc : y_cnt;
    assign sof_hit  = gated_de & (x_cnt == '0) & (y_cnt == '0);
    assign len_err  = line_end & (x_cnt != H_LEN);
    assign cnt_err  = fb & in_pass & (y_line != V_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            vs_d        <= 1'b0;
            de_d        <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            o_v_sync    <= 1'b0;
            o_h_sync    <= 1'b0;
            o_data_en   <= 1'b0;
            o_rgb565    <= '0;
            o_x         <= '0;
            o_y         <= '0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            vs_d      <= i_v_sync;
            de_d      <= i_data_en;
            o_v_sync  <= i_v_sync & (state != IDLE);
            o_h_sync  <= i_h_sync & (state != IDLE);
            o_data_en <= gated_de;
            o_rgb565  <= gated_de ? i_rgb565 : '0;
            o_x       <= gated_de ? x_cnt : '0;
            o_y       <= fb ? '0 : y_line;
            o_sof     <= sof_hit;
            o_eof     <= line_end & (y_inc == V_LEN);

            if (fb || line_end) begin
                x_cnt <= '0;
            end else if (gated_de) begin
                x_cnt <= x_inc;
            end
            y_cnt <= fb ? '0 : y_line;

            // A new error wins over the clear from the start of a frame.
            if (len_err || cnt_err) begin
                o_frame_err <= 1'b1;
            end else if (sof_hit) begin
                o_frame_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_enable) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (!i_enable) begin
                        state <= IDLE;
                    end else if (fb) begin
                        o_busy <= 1'b1;
                        if (i_skip == 2'd0) begin
                            state <= PASS;
                        end else begin
                            state    <= DROP;
                            skip_cnt <= i_skip;
                        end
                    end
                end
                PASS: begin
                    if (fb) begin
                        if (!i_enable) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else if (i_skip != 2'd0) begin
                            state    <= DROP;
                            skip_cnt <= i_skip;
                        end
                    end
                end
                DROP: begin
                    if (fb) begin
                        skip_cnt <= skip_cnt - 2'd1;
                        if (skip_cnt <= 2'd1) begin
                            state  <= i_enable ? PASS : IDLE;
                            o_busy <= i_enable;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
